// File: rtl/tff_pkg.sv
// Shared constants and helpers for the tff counter family.
//   UP / DOWN            : values of the UD direction input
//   WRAP_MODE / SAT_MODE : values of the SAT mode input
//   clog2()              : ceiling log2, used for elaboration-time parameter checks
package tff_pkg;

  localparam logic UP        = 1'b1;
  localparam logic DOWN      = 1'b0;
  localparam logic WRAP_MODE = 1'b0;
  localparam logic SAT_MODE  = 1'b1;

  // Smallest n such that 2**n >= value (0 for value <= 1).
  function automatic int clog2(input longint value);
    int result;
    result = 0;
    for (int i = 0; i < 63; i++) begin
      if ((64'sd1 <<< i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/tff_cell.sv
// Single-bit toggle flip-flop.
//   CK  : clock, rising edge
//   RST : asynchronous active-high reset, forces Q to 0
//   T   : toggle request, Q inverts on the edge when T=1
//   Q   : stored bit
module tff_cell (
  input  logic CK,
  input  logic RST,
  input  logic T,
  output logic Q
);

  always_ff @(posedge CK or posedge RST) begin
    if (RST) Q <= 1'b0;
    else if (T) Q <= ~Q;
  end

endmodule

// File: rtl/tff_counter.sv
// WIDTH-bit modulo-MOD up/down counter built from toggle flip-flop cells.
//   CK   : clock, rising edge
//   RST  : asynchronous active-high reset (Q=0, WRAP=0)
//   EN   : count enable
//   CLR  : synchronous clear (highest priority)
//   LD   : synchronous load of D, clamped to MOD-1
//   D    : load value
//   UD   : direction, 1 = up, 0 = down
//   SAT  : 1 = saturate at range ends, 0 = wrap
//   Q    : current count
//   TC   : terminal count for the current direction (combinational)
//   WRAP : registered pulse, high the cycle after a wrapping edge
module tff_counter
  import tff_pkg::*;
#(
  parameter int     WIDTH = 4,
  parameter longint MOD   = longint'(1) <<< WIDTH
) (
  input  logic             CK,
  input  logic             RST,
  input  logic             EN,
  input  logic             CLR,
  input  logic             LD,
  input  logic [WIDTH-1:0] D,
  input  logic             UD,
  input  logic             SAT,
  output logic [WIDTH-1:0] Q,
  output logic             TC,
  output logic             WRAP
);

  generate
    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
      $error("tff_counter: WIDTH must be in 1..32");
    end
    if (MOD < 2 || clog2(MOD) > WIDTH) begin : g_bad_mod
      $error("tff_counter: MOD must satisfy 2 <= MOD <= 2**WIDTH");
    end
  endgenerate

  localparam logic [WIDTH-1:0] MAX  = WIDTH'(MOD - 1);
  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  logic [WIDTH-1:0] count_next;
  logic [WIDTH-1:0] toggle;
  logic             wrap_next;

  always_comb begin
    count_next = Q;
    wrap_next  = 1'b0;
    if (CLR) begin
      count_next = ZERO;
    end else if (LD) begin
      count_next = (D > MAX) ? MAX : D;
    end else if (EN) begin
      if (UD == UP) begin
        // Out-of-range codes (non power-of-two MOD) recover to the low end.
        if (Q > MAX) begin
          count_next = ZERO;
        end else if (Q == MAX) begin
          if (SAT != SAT_MODE) begin
            count_next = ZERO;
            wrap_next  = 1'b1;
          end
        end else begin
          count_next = Q + ONE;
        end
      end else begin
        if (Q > MAX) begin
          count_next = MAX;
        end else if (Q == ZERO) begin
          if (SAT != SAT_MODE) begin
            count_next = MAX;
            wrap_next  = 1'b1;
          end
        end else begin
          count_next = Q - ONE;
        end
      end
    end
  end

  // Each cell flips exactly the bits that differ between current and next.
  assign toggle = Q ^ count_next;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
      tff_cell u_cell (
        .CK (CK),
        .RST(RST),
        .T  (toggle[gi]),
        .Q  (Q[gi])
      );
    end
  endgenerate

  always_ff @(posedge CK or posedge RST) begin
    if (RST) WRAP <= 1'b0;
    else     WRAP <= wrap_next;
  end

  assign TC = (UD == UP) ? (Q == MAX) : (Q == ZERO);

endmodule
